// File: rtl/lzs_bit_packer.sv
// LZS encoder bit packer: MSB-first variable-width codes into big-endian 16-bit words.
// Flush zero-pads and drains the final partial word, then pulses done.
module lzs_bit_packer #(
  parameter int IN_WIDTH  = 13,
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 code_valid,
  input  logic [IN_WIDTH-1:0]  code_data,
  input  logic [3:0]           code_width,
  output logic                 code_ready,
  input  logic                 flush,
  output logic                 word_valid,
  output logic [15:0]          word_data,
  input  logic                 word_ready,
  output logic                 done,
  output logic [LZF_WIDTH-1:0] byte_count
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [5:0] MAX_CNT = 6'(32 - IN_WIDTH);

  state_t              state;
  logic [31:0]         acc;
  logic [5:0]          cnt;

  logic                emit;
  logic                accept;
  logic [5:0]          cnt_ae;
  logic [31:0]         acc_ae;
  logic [IN_WIDTH-1:0] mask;
  logic [IN_WIDTH-1:0] code_m;
  logic [5:0]          sh;
  logic [31:0]         ins;

  assign word_valid = (state == RUN) ? (cnt >= 6'd16)
                                     : (cnt != 6'd0);
  assign word_data  = acc[31:16];
  assign emit       = word_valid & word_ready;

  always_comb begin
    cnt_ae = cnt;
    if (emit)
      cnt_ae = (cnt >= 6'd16) ? cnt - 6'd16 : 6'd0;
  end

  assign acc_ae = emit ? {acc[15:0], 16'h0000} : acc;

  assign code_ready = (state == RUN) & (cnt_ae <= MAX_CNT);
  assign accept     = code_valid & code_ready;

  // Shifting all-ones past the top leaves zero, so width IN_WIDTH masks nothing.
  assign mask   = ~({IN_WIDTH{1'b1}} << code_width);
  assign code_m = code_data & mask;
  assign sh     = 6'd32 - cnt_ae - {2'b00, code_width};
  assign ins    = 32'(code_m) << sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      acc        <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      done <= 1'b0;
      if (emit)
        byte_count <= byte_count + LZF_WIDTH'(2);
      unique case (state)
        RUN: begin
          if (accept) begin
            acc <= acc_ae | ins;
            cnt <= cnt_ae + {2'b00, code_width};
          end else begin
            acc <= acc_ae;
            cnt <= cnt_ae;
          end
          if (flush & ~code_valid)
            state <= FLUSH;
        end
        FLUSH: begin
          if (cnt_ae == 6'd0) begin
            done  <= 1'b1;
            state <= RUN;
            acc   <= '0;
            cnt   <= '0;
          end else begin
            acc <= acc_ae;
            cnt <= cnt_ae;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_lzs_bit_packer.sv
// Bench for lzs_bit_packer: bit-queue reference model, directed cases,
// random codes with random backpressure, and an MSB-first stream readback.
module tb_lzs_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic [12:0] code_data;
  logic [3:0]  code_width;
  logic        code_ready;
  logic        flush;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;
  logic        done;
  logic [19:0] byte_count;

  lzs_bit_packer #(.IN_WIDTH(13), .LZF_WIDTH(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_data  (code_data),
    .code_width (code_width),
    .code_ready (code_ready),
    .flush      (flush),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (code_valid)
      assert (code_width <= 4'd13);

  int n_chk = 0;
  int n_err = 0;

  // model: pending bits in stream order
  bit          q[$];
  bit          mflush;
  bit          mdone;
  int          mbytes;
  // observed stream and sent codes
  logic [15:0] rx[$];
  int          cw[$];
  logic [12:0] cd[$];
  bit          rec;
  int          ndone;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr_model();
    q.delete();
    mflush = 0;
    mdone  = 0;
    mbytes = 0;
  endtask

  task automatic do_reset();
    code_valid = 0;
    code_data  = '0;
    code_width = '0;
    flush      = 0;
    word_ready = 0;
    rst        = 1;
    @(posedge clk);
    #1;
    rst = 0;
    clr_model();
  endtask

  task automatic step(input bit v, input logic [12:0] d,
                      input logic [3:0] w, input bit f, input bit wr);
    int          len;
    int          after;
    bit          ewv;
    bit          emit;
    bit          ecr;
    logic [15:0] ewd;
    code_valid = v;
    code_data  = d;
    code_width = w;
    flush      = f;
    word_ready = wr;
    #2;
    len = q.size();
    ewv = mflush ? (len > 0) : (len >= 16);
    for (int i = 0; i < 16; i++)
      ewd[15-i] = (i < len) ? q[i] : 1'b0;
    emit  = ewv && wr;
    after = emit ? ((len >= 16) ? len - 16 : 0) : len;
    ecr   = !mflush && (after <= 19);
    chk("word_valid", 32'(word_valid), 32'(ewv));
    if (ewv)
      chk("word_data", 32'(word_data), 32'(ewd));
    chk("code_ready", 32'(code_ready), 32'(ecr));
    chk("done", 32'(done), 32'(mdone));
    chk("byte_count", 32'(byte_count), 32'(mbytes % (1 << 20)));
    if (done)
      ndone++;
    if (word_valid && wr)
      rx.push_back(word_data);
    @(posedge clk);
    #1;
    if (emit) begin
      for (int i = 0; i < 16 && q.size() > 0; i++)
        void'(q.pop_front());
      mbytes += 2;
    end
    if (v && ecr) begin
      for (int k = int'(w) - 1; k >= 0; k--)
        q.push_back(d[k]);
      if (rec && w != 0) begin
        cw.push_back(int'(w));
        cd.push_back(d & ~(13'h1FFF << w));
      end
    end
    if (mflush) begin
      mdone = (after == 0);
      if (after == 0)
        mflush = 0;
    end else begin
      mdone = 0;
      if (f && !v)
        mflush = 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++)
      step(0, '0, '0, 0, 1);
  endtask

  initial begin
    logic [63:0] sr;
    int          nb;
    int          wi;
    int          tot;
    int          acc_n;
    int          cyc;
    logic [12:0] got;
    rec   = 0;
    ndone = 0;
    do_reset();

    // reset state
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_code_ready", 32'(code_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_bytes", 32'(byte_count), 0);

    // two codes complete a word
    step(1, 13'h1FF, 4'd9, 0, 1);
    step(1, 13'h000, 4'd7, 0, 1);
    chk("t1_valid", 32'(word_valid), 1);
    chk("t1_word", 32'(word_data), 32'h0000FF80);
    step(0, '0, '0, 0, 1);
    chk("t1_bytes", 32'(byte_count), 2);
    chk("t1_empty", 32'(word_valid), 0);
    drain();

    // flush of a partial word
    ndone = 0;
    step(1, 13'h00A, 4'd4, 0, 1);
    step(0, '0, '0, 1, 1);
    chk("t2_ready_fl", 32'(code_ready), 0);
    chk("t2_word", 32'(word_data), 32'h0000A000);
    step(1, 13'h0FF, 4'd8, 0, 1);
    chk("t2_done", 32'(done), 1);
    for (int i = 0; i < 4; i++)
      step(0, '0, '0, 0, 1);
    chk("t2_done_once", ndone, 1);

    // backpressure
    do_reset();
    step(1, 13'h1ABC, 4'd13, 0, 0);
    step(1, 13'h0123, 4'd13, 0, 0);
    chk("bp_ready", 32'(code_ready), 0);
    chk("bp_word", 32'(word_data), 32'h0000D5E0);
    step(1, 13'h0555, 4'd13, 0, 0);
    step(1, 13'h0555, 4'd13, 0, 0);
    chk("bp_hold", 32'(word_data), 32'h0000D5E0);
    step(1, 13'h0555, 4'd13, 0, 1);
    step(1, 13'h0AAA, 4'd13, 0, 1);
    drain();

    // masking and zero-width no-op
    do_reset();
    step(1, 13'h1FFF, 4'd1, 0, 0);
    step(1, 13'h1FFF, 4'd0, 0, 0);
    step(1, 13'h1F00, 4'd8, 0, 0);
    step(1, 13'h1F80, 4'd7, 0, 0);
    chk("mask_valid", 32'(word_valid), 1);
    chk("mask_word", 32'(word_data), 32'h00008000);
    drain();

    // reset while flushing 12 bits
    do_reset();
    step(1, 13'h0ABC, 4'd12, 0, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 0, 0);
    chk("rf_pending", 32'(word_valid), 1);
    do_reset();
    chk("rf_word_valid", 32'(word_valid), 0);
    chk("rf_code_ready", 32'(code_ready), 1);
    chk("rf_bytes", 32'(byte_count), 0);
    chk("rf_done", 32'(done), 0);
    step(0, '0, '0, 0, 1);
    step(0, '0, '0, 0, 1);

    // random codes, random backpressure, then flush
    do_reset();
    rx.delete();
    rec   = 1;
    acc_n = 0;
    cyc   = 0;
    while (cw.size() + acc_n < 10000 && cyc < 40000) begin
      logic [12:0] d;
      logic [3:0]  w;
      bit          v;
      d = 13'($urandom);
      w = 4'($urandom_range(0, 13));
      v = ($urandom % 4) != 0;
      if (v && w == 0 && code_ready)
        acc_n++;
      step(v, d, w, 0, 1'($urandom));
      cyc++;
    end
    if (cyc >= 40000)
      chk("rnd_timeout", 0, 1);
    rec = 0;
    step(0, '0, '0, 1, 1'($urandom));
    cyc = 0;
    while (!mdone && cyc < 40) begin
      step(0, '0, '0, 0, 1'($urandom));
      cyc++;
    end
    if (!mdone)
      chk("flush_timeout", 0, 1);
    step(0, '0, '0, 0, 1);
    chk("rnd_bytes", 32'(byte_count), 32'(2 * rx.size()));

    tot = 0;
    foreach (cw[i])
      tot += cw[i];
    chk("rnd_nwords", rx.size(), (tot + 15) / 16);
    sr = '0;
    nb = 0;
    wi = 0;
    foreach (cw[i]) begin
      while (nb < cw[i] && wi < rx.size()) begin
        sr |= {48'h0, rx[wi]} << (48 - nb);
        nb += 16;
        wi++;
      end
      got = 13'(sr >> (64 - cw[i]));
      chk("rnd_code", 32'(got), 32'(cd[i]));
      sr = sr << cw[i];
      nb -= cw[i];
    end
    chk("rnd_pad", 32'(sr == 64'h0), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
